// File: rtl/i2cs_core_pkg.sv
// Shared I2C bus constants and helpers for the i2cs responder.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package i2cs_core_pkg;

    // Bus-level acknowledge encoding as seen on SDA during the 9th clock
    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;

    // Direction bit position within the address byte and its codes
    localparam int   RW_BIT   = 0;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // True when the upper seven bits of a received address byte select this slave
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] slv_addr);
        return (addr_byte[7:1] == slv_addr);
    endfunction

endpackage

// File: rtl/i2cs_filt.sv
// Synchronizes one asynchronous bus pad and removes glitches shorter than FILT clocks.
// Latency: 2 sync stages + FILT agreeing samples before the filtered level moves.
// Backpressure: none; o_rise/o_fall are single-cycle pulses aligned with the level change.
//
// Ports:
//   clk, rst  system clock, asynchronous active-high reset (level resets to 1 = idle bus)
//   i_pad     raw pad input
//   o_lvl     filtered level
//   o_rise    one-cycle pulse when o_lvl goes 0->1
//   o_fall    one-cycle pulse when o_lvl goes 1->0
module i2cs_filt #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pad,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

    logic          r_s1;
    logic          r_s2;
    logic          r_lvl;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // r_cnt counts consecutive synchronized samples that disagree with the
    // current filtered level; the level flips on the FILT-th such sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_lvl  <= 1'b1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_s1   <= i_pad;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_s2 != r_lvl) begin
                if (r_cnt == CW'(FILT - 1)) begin
                    r_lvl  <= r_s2;
                    r_rise <= r_s2;
                    r_fall <= ~r_s2;
                    r_cnt  <= '0;
                end else begin
                    r_cnt  <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_lvl  = r_lvl;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/i2cs_core.sv
// I2C responder mapping bus transfers onto an 8-bit register port with auto-increment pointer.
// Latency: strobes follow the filtered SCL edge by one clk; reg_rdata is captured one clk after reg_re.
// Backpressure: none; no clock stretching, the bus master sets the pace.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   scl_i, sda_i  asynchronous pad inputs
//   sda_oe        1 = pull SDA low, 0 = release
//   reg_addr      register pointer of the current access
//   reg_wdata     write data, valid while reg_we
//   reg_we        one-cycle write strobe
//   reg_re        one-cycle read strobe; reg_rdata sampled on the following clk
//   reg_rdata     read data
//   busy          1 while the FSM is outside IDLE
module i2cs_core
    import i2cs_core_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         FILT     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK
    } state_t;

    logic w_scl_lvl;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_sda_lvl;
    logic w_sda_rise;
    logic w_sda_fall;
    logic w_start;
    logic w_stop;

    state_t     r_state;
    logic [3:0] r_bitcnt;
    logic [7:0] r_shift;
    logic [7:0] r_ptr;
    logic       r_first;
    logic       r_rw;
    logic       r_rack;
    logic       r_load;
    logic       r_sda_oe;
    logic [7:0] r_reg_addr;
    logic [7:0] r_reg_wdata;
    logic       r_reg_we;
    logic       r_reg_re;

    i2cs_filt #(.FILT(FILT)) u_scl_filt (
        .clk    (clk),
        .rst    (rst),
        .i_pad  (scl_i),
        .o_lvl  (w_scl_lvl),
        .o_rise (w_scl_rise),
        .o_fall (w_scl_fall)
    );

    i2cs_filt #(.FILT(FILT)) u_sda_filt (
        .clk    (clk),
        .rst    (rst),
        .i_pad  (sda_i),
        .o_lvl  (w_sda_lvl),
        .o_rise (w_sda_rise),
        .o_fall (w_sda_fall)
    );

    // Both lines share the same filter delay, so SCL level is still valid
    // when the SDA edge emerges.
    assign w_start = w_sda_fall & w_scl_lvl;
    assign w_stop  = w_sda_rise & w_scl_lvl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bitcnt    <= 4'd0;
            r_shift     <= 8'h00;
            r_ptr       <= 8'h00;
            r_first     <= 1'b0;
            r_rw        <= 1'b0;
            r_rack      <= 1'b0;
            r_load      <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_reg_addr  <= 8'h00;
            r_reg_wdata <= 8'h00;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
        end else begin
            r_reg_we <= 1'b0;
            r_reg_re <= 1'b0;
            r_load   <= 1'b0;

            // Read data arrives one clk after the read strobe; the next SCL fall
            // is many clocks away so this never races the shift below.
            if (r_load) begin
                r_shift <= reg_rdata;
            end

            if (w_start) begin
                r_state  <= ST_ADDR;
                r_bitcnt <= 4'd0;
                r_sda_oe <= 1'b0;
                r_rack   <= 1'b0;
            end else if (w_stop) begin
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
                r_rack   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_sda_oe <= 1'b0;
                    end

                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift  <= {r_shift[6:0], w_sda_lvl};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_scl_fall && (r_bitcnt == 4'd8)) begin
                            if (addr_match(r_shift, SLV_ADDR)) begin
                                r_sda_oe <= 1'b1;
                                r_rw     <= (r_shift[RW_BIT] == RW_READ);
                                r_state  <= ST_ADDR_ACK;
                            end else begin
                                r_state  <= ST_IDLE;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (w_scl_rise && r_rw) begin
                            r_reg_re   <= 1'b1;
                            r_reg_addr <= r_ptr;
                            r_ptr      <= r_ptr + 8'd1;
                            r_load     <= 1'b1;
                        end else if (w_scl_fall) begin
                            if (r_rw) begin
                                r_sda_oe <= ~r_shift[7];
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_bitcnt <= 4'd1;
                                r_state  <= ST_RD_BYTE;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_first  <= 1'b1;
                                r_bitcnt <= 4'd0;
                                r_state  <= ST_WR_BYTE;
                            end
                        end
                    end

                    ST_WR_BYTE: begin
                        if (w_scl_rise) begin
                            r_shift  <= {r_shift[6:0], w_sda_lvl};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_scl_fall && (r_bitcnt == 4'd8)) begin
                            r_sda_oe <= 1'b1;
                            r_state  <= ST_WR_ACK;
                            // First byte after a write address is the pointer itself
                            if (r_first) begin
                                r_ptr   <= r_shift;
                                r_first <= 1'b0;
                            end else begin
                                r_reg_we    <= 1'b1;
                                r_reg_addr  <= r_ptr;
                                r_reg_wdata <= r_shift;
                                r_ptr       <= r_ptr + 8'd1;
                            end
                        end
                    end

                    ST_WR_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_bitcnt <= 4'd0;
                            r_state  <= ST_WR_BYTE;
                        end
                    end

                    ST_RD_BYTE: begin
                        if (w_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_rack   <= 1'b0;
                                r_state  <= ST_RD_ACK;
                            end else begin
                                r_sda_oe <= ~r_shift[7];
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_bitcnt <= r_bitcnt + 4'd1;
                            end
                        end
                    end

                    ST_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda_lvl == ACK) begin
                                r_reg_re   <= 1'b1;
                                r_reg_addr <= r_ptr;
                                r_ptr      <= r_ptr + 8'd1;
                                r_load     <= 1'b1;
                                r_rack     <= 1'b1;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_IDLE;
                            end
                        end else if (w_scl_fall && r_rack) begin
                            r_rack   <= 1'b0;
                            r_sda_oe <= ~r_shift[7];
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_bitcnt <= 4'd1;
                            r_state  <= ST_RD_BYTE;
                        end
                    end

                    default: begin
                        r_sda_oe <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sda_oe    = r_sda_oe;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_we    = r_reg_we;
    assign reg_re    = r_reg_re;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_i2cs_core.sv
// Directed bench for i2cs_core: open-drain bus master model and register model mem[a] = a ^ 8'h5A.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2cs_core;

    localparam int Q = 20;  // quarter SCL period in clk cycles

    logic       clk;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] we_addr_q[$];
    logic [7:0] we_dat_q[$];
    logic [7:0] re_addr_q[$];
    int         both_cnt = 0;
    logic       oe_seen  = 1'b0;

    assign sda_line  = sda_m & ~sda_oe;
    assign reg_rdata = reg_addr ^ 8'h5A;

    i2cs_core #(.SLV_ADDR(7'h50), .FILT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_m),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (reg_we) begin
            we_addr_q.push_back(reg_addr);
            we_dat_q.push_back(reg_wdata);
        end
        if (reg_re) re_addr_q.push_back(reg_addr);
        if (reg_we && reg_re) both_cnt++;
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] qat(input logic [7:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 8'hxx;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        we_addr_q.delete();
        we_dat_q.delete();
        re_addr_q.delete();
        oe_seen = 1'b0;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_rstart();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    // Glitch mode adds a 1-clk SCL low pulse and, for 1 bits, a 1-clk SDA low
    // pulse while SCL is high (a false START if it got through the filter).
    task automatic write_bit(input logic b, input logic glitch);
        sda_m = b; wait_clk(Q);
        scl_m = 1'b1;
        if (glitch) begin
            wait_clk(8);
            scl_m = 1'b0; wait_clk(1);
            scl_m = 1'b1; wait_clk(8);
            if (b) begin
                sda_m = 1'b0; wait_clk(1); sda_m = 1'b1;
            end else begin
                wait_clk(1);
            end
            wait_clk(2*Q - 18);
        end else begin
            wait_clk(2*Q);
        end
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic glitch, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i], glitch);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        ack = sda_line;
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] data);
        data  = 8'h00;
        sda_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_clk(Q);
            scl_m = 1'b1; wait_clk(Q);
            data = {data[6:0], sda_line};
            wait_clk(Q);
            scl_m = 1'b0;
        end
        wait_clk(Q);
        sda_m = ack_bit; wait_clk(Q);
        scl_m = 1'b1; wait_clk(2*Q);
        scl_m = 1'b0; wait_clk(Q);
        sda_m = 1'b1;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        wait_clk(3);
        check("rst_sda_oe",    {31'd0, sda_oe}, 32'd0);
        check("rst_reg_we",    {31'd0, reg_we}, 32'd0);
        check("rst_reg_re",    {31'd0, reg_re}, 32'd0);
        check("rst_reg_addr",  {24'd0, reg_addr}, 32'd0);
        check("rst_reg_wdata", {24'd0, reg_wdata}, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_clk(10);

        // 1: pointer write then two data bytes
        clear_logs();
        bus_start();
        check("t1_busy_after_start", {31'd0, busy}, 32'd1);
        write_byte(8'hA0, 1'b0, ack); check("t1_ack_addr", {31'd0, ack}, 32'd0);
        write_byte(8'h10, 1'b0, ack); check("t1_ack_ptr",  {31'd0, ack}, 32'd0);
        write_byte(8'hAB, 1'b0, ack); check("t1_ack_d0",   {31'd0, ack}, 32'd0);
        write_byte(8'hCD, 1'b0, ack); check("t1_ack_d1",   {31'd0, ack}, 32'd0);
        bus_stop();
        check("t1_we_count", we_addr_q.size(), 32'd2);
        check("t1_we0_addr", {24'd0, qat(we_addr_q, 0)}, 32'h10);
        check("t1_we0_data", {24'd0, qat(we_dat_q, 0)},  32'hAB);
        check("t1_we1_addr", {24'd0, qat(we_addr_q, 1)}, 32'h11);
        check("t1_we1_data", {24'd0, qat(we_dat_q, 1)},  32'hCD);
        check("t1_ptr",      {24'd0, dut.r_ptr}, 32'h12);
        check("t1_busy_after_stop", {31'd0, busy}, 32'd0);

        // 2: set pointer, repeated START, read three bytes
        clear_logs();
        bus_start();
        write_byte(8'hA0, 1'b0, ack); check("t2_ack_waddr", {31'd0, ack}, 32'd0);
        write_byte(8'h05, 1'b0, ack); check("t2_ack_ptr",   {31'd0, ack}, 32'd0);
        bus_rstart();
        write_byte(8'hA1, 1'b0, ack); check("t2_ack_raddr", {31'd0, ack}, 32'd0);
        read_byte(1'b0, rd); check("t2_rd0", {24'd0, rd}, 32'h5F);
        read_byte(1'b0, rd); check("t2_rd1", {24'd0, rd}, 32'h5C);
        read_byte(1'b1, rd); check("t2_rd2", {24'd0, rd}, 32'h5D);
        check("t2_busy_after_nack", {31'd0, busy}, 32'd0);
        bus_stop();
        check("t2_re_count", re_addr_q.size(), 32'd3);
        check("t2_re0", {24'd0, qat(re_addr_q, 0)}, 32'h05);
        check("t2_re1", {24'd0, qat(re_addr_q, 1)}, 32'h06);
        check("t2_re2", {24'd0, qat(re_addr_q, 2)}, 32'h07);
        check("t2_we_count", we_addr_q.size(), 32'd0);
        check("t2_ptr", {24'd0, dut.r_ptr}, 32'h08);

        // 3: address mismatch, slave must stay silent
        clear_logs();
        bus_start();
        write_byte(8'hA2, 1'b0, ack); check("t3_nack_addr", {31'd0, ack}, 32'd1);
        check("t3_busy_after_addr", {31'd0, busy}, 32'd0);
        write_byte(8'h33, 1'b0, ack); check("t3_nack_data", {31'd0, ack}, 32'd1);
        bus_stop();
        check("t3_oe_seen",   {31'd0, oe_seen}, 32'd0);
        check("t3_we_count",  we_addr_q.size(), 32'd0);
        check("t3_re_count",  re_addr_q.size(), 32'd0);
        check("t3_ptr",       {24'd0, dut.r_ptr}, 32'h08);

        // 4: glitches inside data bytes, pointer wraps FF -> 00
        clear_logs();
        bus_start();
        write_byte(8'hA0, 1'b0, ack); check("t4_ack_addr", {31'd0, ack}, 32'd0);
        write_byte(8'hFF, 1'b1, ack); check("t4_ack_ptr",  {31'd0, ack}, 32'd0);
        write_byte(8'h11, 1'b1, ack); check("t4_ack_d0",   {31'd0, ack}, 32'd0);
        write_byte(8'h22, 1'b1, ack); check("t4_ack_d1",   {31'd0, ack}, 32'd0);
        bus_stop();
        check("t4_we_count", we_addr_q.size(), 32'd2);
        check("t4_we0_addr", {24'd0, qat(we_addr_q, 0)}, 32'hFF);
        check("t4_we0_data", {24'd0, qat(we_dat_q, 0)},  32'h11);
        check("t4_we1_addr", {24'd0, qat(we_addr_q, 1)}, 32'h00);
        check("t4_we1_data", {24'd0, qat(we_dat_q, 1)},  32'h22);
        check("t4_ptr",      {24'd0, dut.r_ptr}, 32'h01);

        // 5a: STOP after 3 data bits discards the partial byte
        clear_logs();
        bus_start();
        write_byte(8'hA0, 1'b0, ack); check("t5_ack_addr", {31'd0, ack}, 32'd0);
        write_byte(8'h40, 1'b0, ack); check("t5_ack_ptr",  {31'd0, ack}, 32'd0);
        write_bit(1'b1, 1'b0);
        write_bit(1'b0, 1'b0);
        write_bit(1'b1, 1'b0);
        bus_stop();
        check("t5_we_count", we_addr_q.size(), 32'd0);
        check("t5_ptr",      {24'd0, dut.r_ptr}, 32'h40);
        check("t5_busy",     {31'd0, busy}, 32'd0);

        // 5b: async reset while the slave drives a 0 data bit (mem[30] = 6A)
        clear_logs();
        bus_start();
        write_byte(8'hA0, 1'b0, ack);
        write_byte(8'h30, 1'b0, ack);
        bus_rstart();
        write_byte(8'hA1, 1'b0, ack); check("t5_ack_raddr", {31'd0, ack}, 32'd0);
        check("t5_oe_driving", {31'd0, sda_oe}, 32'd1);
        #4 rst = 1'b1;
        #1;
        check("t5_oe_async_rst", {31'd0, sda_oe}, 32'd0);
        check("t5_ptr_rst",      {24'd0, dut.r_ptr}, 32'h00);
        check("t5_busy_rst",     {31'd0, busy}, 32'd0);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(10);
        bus_stop();
        check("t5_busy_end", {31'd0, busy}, 32'd0);
        check("no_we_re_overlap", both_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
